// File: rtl/adder_pipeline_ctrl.sv
// Sequencing controller for the cascaded parity-protected adder pipeline.
// Tracks per-layer valid bits, drives per-layer hold signals from a
// valid/ready handshake, qualifies raw parity errors into a one-cycle alarm
// and runs a LAYERS-cycle scrub/flush after reset and after every alarm.
// Optional build macro ADDER_CTRL_ERR_COUNT_EN adds a saturating alarm
// counter (err_count) with a synchronous clear (err_count_clr).
module adder_pipeline_ctrl #(
  parameter int unsigned LAYERS    = 3,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LAYERS-1:0] hold_signals,
  input  logic [LAYERS-1:0] error_signals,
  output logic              alarm,
  output logic              flushing
`ifdef ADDER_CTRL_ERR_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] err_count,
  input  logic                 err_count_clr
`endif
);

  localparam int unsigned FW = $clog2(LAYERS + 1);

  typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   fcnt;
  logic [LAYERS:1] v;
  logic [LAYERS:1] vin;
  logic [LAYERS:1] rdy;
  logic [LAYERS-1:0] qerr;
  logic            any_qerr;
  logic            run;
  logic            fcnt_last;

  assign run       = (state == RUN);
  assign fcnt_last = (fcnt == FW'(LAYERS - 1));

  // Ready chain from the output end back to layer 1; a pending error in the
  // last layer blocks its consumption.
  always_comb begin
    rdy = '0;
    rdy[LAYERS] = ~v[LAYERS] | (out_ready & ~error_signals[LAYERS-1]);
    for (int unsigned k = LAYERS - 1; k >= 1; k--) begin
      rdy[k] = ~v[k] | rdy[k+1];
    end
  end

  // Valid source per layer: layer 1 takes the input handshake, others the layer before.
  always_comb begin
    vin = '0;
    vin[1] = in_valid & in_ready;
    for (int unsigned k = 2; k <= LAYERS; k++) begin
      vin[k] = v[k-1];
    end
  end

  // An error only qualifies when its word is about to move on or be consumed.
  always_comb begin
    qerr = '0;
    for (int unsigned i = 0; i + 1 < LAYERS; i++) begin
      qerr[i] = error_signals[i] & v[i+1] & rdy[i+2];
    end
    qerr[LAYERS-1] = error_signals[LAYERS-1] & v[LAYERS] & out_ready;
    any_qerr = run & (|qerr);
  end

  // State, flush counter, valid vector and alarm registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      fcnt  <= '0;
      v     <= '0;
      alarm <= 1'b0;
    end else begin
      state <= state_nxt;
      alarm <= any_qerr;
      if (!run) fcnt <= fcnt_last ? '0 : fcnt + 1'b1;
      else      fcnt <= '0;
      if (!run || any_qerr) v <= '0;
      else                  v <= (v & ~rdy) | (vin & rdy);
    end
  end

  // Next-state: INIT and FLUSH both scrub for LAYERS cycles before RUN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT, FLUSH: if (fcnt_last) state_nxt = RUN;
      RUN:         if (any_qerr)  state_nxt = FLUSH;
      default:     state_nxt = INIT;
    endcase
  end

  // Outputs: everything loads and no handshakes complete while scrubbing.
  always_comb begin
    hold_signals = '0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    flushing     = ~run;
    if (run) begin
      hold_signals = ~rdy;
      in_ready     = rdy[1];
      out_valid    = v[LAYERS] & ~error_signals[LAYERS-1];
    end
  end

`ifdef ADDER_CTRL_ERR_COUNT_EN
  // Saturating count of qualified errors; clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_count <= '0;
    else if (err_count_clr)             err_count <= '0;
    else if (any_qerr && err_count != '1) err_count <= err_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_adder_pipeline_ctrl.sv
// Self-checking bench for adder_pipeline_ctrl (LAYERS=3). A small data
// pipeline in the bench is steered by the DUT hold signals; a scoreboard
// queue checks ordering and loss/duplication of words.
module tb_adder_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] hold_signals;
  logic [2:0] error_signals;
  logic       alarm;
  logic       flushing;
`ifdef ADDER_CTRL_ERR_COUNT_EN
  logic [1:0] err_count;
  logic       err_count_clr;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] in_data = 32'd1;
  logic [31:0] d1, d2, d3;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  adder_pipeline_ctrl #(.LAYERS(3), .CNT_WIDTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .hold_signals (hold_signals),
    .error_signals(error_signals),
    .alarm        (alarm),
    .flushing     (flushing)
`ifdef ADDER_CTRL_ERR_COUNT_EN
    ,
    .err_count    (err_count),
    .err_count_clr(err_count_clr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bench datapath plus scoreboard push (accept) and pop (consume).
  always @(posedge clk) begin
    if (!rst_n) begin
      d1 <= '0; d2 <= '0; d3 <= '0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else                  chk("sb_data", d3, sb_q.pop_front());
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(in_data);
        in_data <= in_data + 1;
      end
      if (!hold_signals[2]) d3 <= d2;
      if (!hold_signals[1]) d2 <= d1;
      if (!hold_signals[0]) d1 <= in_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (alarm) sb_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; error_signals = '0;
`ifdef ADDER_CTRL_ERR_COUNT_EN
    err_count_clr = 1'b0;
`endif
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_hold", hold_signals, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flushing", flushing, 1);
    chk("rst_alarm", alarm, 0);
    #1 rst_n = 1'b1;

    // Initial scrub: exactly three cycles without in_ready.
    for (int i = 0; i < 3; i++) begin
      chk("init_in_ready", in_ready, 0);
      chk("init_hold", hold_signals, 0);
      cyc();
    end
    chk("init_done_ready", in_ready, 1);
    chk("init_done_flush", flushing, 0);

    // Back-to-back stream of four words.
    for (int j = 0; j < 10; j++) begin
      in_valid = (j < 4);
      #0;
      chk("stream_hold", hold_signals, 0);
      chk("stream_out_valid", out_valid, (j >= 3 && j <= 6) ? 1 : 0);
      cyc();
    end
    chk("stream_drained", sb_q.size(), 0);

    // Fill then stall the output.
    out_ready = 1'b0; in_valid = 1'b1;
    cyc(); cyc(); cyc();
    for (int j = 0; j < 5; j++) begin
      chk("stall_hold", hold_signals, 3'b111);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 4; j++) cyc();
    chk("stall_out_valid_end", out_valid, 0);
    chk("stall_drained", sb_q.size(), 0);

    // Layer-1 error with its word moving into layer 2.
    in_valid = 1'b1;
    cyc(); cyc();
    in_valid = 1'b0; error_signals = 3'b001;
    #1;
    chk("e1_pre_alarm", alarm, 0);
    cyc();
    chk("e1_alarm", alarm, 1);
    chk("e1_flushing1", flushing, 1);
    chk("e1_out_valid", out_valid, 0);
    chk("e1_in_ready", in_ready, 0);
    error_signals = '0;
    cyc();
    chk("e1_alarm_clear", alarm, 0);
    chk("e1_flushing2", flushing, 1);
    cyc();
    chk("e1_flushing3", flushing, 1);
    cyc();
    chk("e1_run", flushing, 0);
    chk("e1_empty", out_valid, 0);
    chk("e1_hold", hold_signals, 0);

    // Last-layer error held back by out_ready=0.
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    error_signals = 3'b100;
    #1;
    chk("e3_out_valid_masked", out_valid, 0);
    chk("e3_hold", hold_signals, 3'b100);
    chk("e3_no_alarm", alarm, 0);
    cyc();
    chk("e3_no_alarm2", alarm, 0);
    chk("e3_no_flush", flushing, 0);
    out_ready = 1'b1;
    #1;
    chk("e3_out_valid_masked2", out_valid, 0);
    cyc();
    chk("e3_alarm", alarm, 1);
    chk("e3_flushing", flushing, 1);
    error_signals = '0;
    cyc();
    chk("e3_alarm_clear", alarm, 0);
    cyc(); cyc();
    chk("e3_run", flushing, 0);
    chk("e3_in_ready", in_ready, 1);

    // Asynchronous reset mid-operation.
    in_valid = 1'b1;
    cyc(); cyc();
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    sb_q.delete();
    chk("mid_rst_flushing", flushing, 1);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_hold", hold_signals, 0);
    #3 rst_n = 1'b1;
    cyc(); cyc(); cyc();
    chk("mid_rst_run", flushing, 0);
    chk("mid_rst_out_valid", out_valid, 0);

`ifdef ADDER_CTRL_ERR_COUNT_EN
    chk("cnt_reset", err_count, 0);
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc(); cyc();
      error_signals = 3'b100;
      err_count_clr = (n == 4);
      cyc();
      error_signals = '0; err_count_clr = 1'b0;
      chk("cnt_alarm", alarm, 1);
      chk("cnt_value", err_count, (n == 4) ? 0 : (n >= 2 ? 3 : n + 1));
      cyc(); cyc(); cyc();
    end
`endif

    chk("final_sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
